// File: rtl/stack_access_unit_if.sv
// Bundle of the core-side request/response signals, the stack pointer hookup
// and the 16-bit data memory port used by stack_access_unit.
interface stack_access_if #(
   parameter int ADDR_W = 20
);
   logic              req;
   logic [1:0]        op;
   logic [31:0]       wdata;
   logic [31:0]       sp_in;
   logic              busy;
   logic              done;
   logic              err;
   logic [31:0]       rdata;
   logic [2:0]        sp_ctrl;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [15:0]       mem_rdata;

   modport slave (
      input  req, op, wdata, sp_in, mem_rdata,
      output busy, done, err, rdata, sp_ctrl, mem_addr, mem_wdata, mem_we, mem_re
   );

   modport master (
      output req, op, wdata, sp_in, mem_rdata,
      input  busy, done, err, rdata, sp_ctrl, mem_addr, mem_wdata, mem_we, mem_re
   );
endinterface

// File: rtl/stack_access_unit.sv
// Push/pop sequencer: splits 32-bit stack values into two 16-bit memory
// accesses and pulses the stack pointer control once per completed transaction.
module stack_access_unit #(
   parameter int                ADDR_W      = 20,
   parameter logic [ADDR_W-1:0] STACK_TOP   = '1,
   parameter logic [ADDR_W-1:0] STACK_LIMIT = '0
) (
   input  logic          clk,
   input  logic          Rst,
   stack_access_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, WR_HI, WR_LO, RD_1, RD_2, RD_CAP, DONE
   } state_t;

   localparam logic [2:0] SP_HOLD = 3'b000;
   localparam logic [2:0] SP_INC2 = 3'b001;
   localparam logic [2:0] SP_DEC2 = 3'b010;
   localparam logic [2:0] SP_INC1 = 3'b011;
   localparam logic [2:0] SP_DEC1 = 3'b100;

   localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_TWO = ADDR_W'(2);
   localparam logic [ADDR_W:0]   X_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   X_TWO = (ADDR_W+1)'(2);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [1:0]        op_q, op_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [ADDR_W:0]   base_x, n_x;
   logic              bound_err;
   logic              unused_sp_hi;

   assign unused_sp_hi = ^bus.sp_in[31:ADDR_W];

   // One extra bit keeps base+n and LIMIT+n-1 from wrapping at the address ends.
   assign base_x    = {1'b0, bus.sp_in[ADDR_W-1:0]};
   assign n_x       = bus.op[0] ? X_TWO : X_ONE;
   assign bound_err = bus.op[1] ? ((base_x + n_x) > {1'b0, STACK_TOP})
                                : (base_x < ({1'b0, STACK_LIMIT} + n_x - X_ONE));

   always_ff @(posedge clk) begin
      if (Rst) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      base_q  <= base_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
   end

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      op_d    = op_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (bus.req) begin
               base_d  = bus.sp_in[ADDR_W-1:0];
               op_d    = bus.op;
               wdata_d = bus.wdata;
               err_d   = bound_err;
               if (bound_err)      state_d = DONE;
               else if (bus.op[1]) state_d = RD_1;
               else if (bus.op[0]) state_d = WR_HI;
               else                state_d = WR_LO;
            end
         end
         WR_HI:  state_d = WR_LO;
         WR_LO:  state_d = DONE;
         RD_1:   state_d = op_q[0] ? RD_2 : RD_CAP;
         RD_2: begin
            rdata_d[15:0] = bus.mem_rdata;
            state_d       = RD_CAP;
         end
         RD_CAP: begin
            if (op_q[0]) rdata_d[31:16] = bus.mem_rdata;
            else         rdata_d        = {16'h0, bus.mem_rdata};
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_wdata = 16'h0;
      bus.mem_we    = 1'b0;
      bus.mem_re    = 1'b0;
      bus.sp_ctrl   = SP_HOLD;
      case (state_q)
         WR_HI: begin
            bus.mem_addr  = base_q;
            bus.mem_wdata = wdata_q[31:16];
            bus.mem_we    = 1'b1;
         end
         WR_LO: begin
            bus.mem_addr  = op_q[0] ? (base_q - A_ONE) : base_q;
            bus.mem_wdata = wdata_q[15:0];
            bus.mem_we    = 1'b1;
            bus.sp_ctrl   = op_q[0] ? SP_DEC2 : SP_DEC1;
         end
         RD_1: begin
            bus.mem_addr = base_q + A_ONE;
            bus.mem_re   = 1'b1;
            bus.sp_ctrl  = op_q[0] ? SP_HOLD : SP_INC1;
         end
         RD_2: begin
            bus.mem_addr = base_q + A_TWO;
            bus.mem_re   = 1'b1;
            bus.sp_ctrl  = SP_INC2;
         end
         default: ;
      endcase
   end

   assign bus.busy  = (state_q != IDLE);
   assign bus.done  = (state_q == DONE);
   assign bus.err   = (state_q == DONE) && err_q;
   assign bus.rdata = rdata_q;

endmodule

// File: doc/stack_access_unit.md
Name: stack_access_unit

Overview:
- Sequencer that executes stack push and pop transactions against the 16-bit-wide, 1M-word data memory on behalf of the core.
- Splits 32-bit values into two 16-bit accesses and computes addresses from the current stack pointer value.
- Issues the 3-bit control code that the stack pointer register consumes, so the pointer moves exactly once per completed transaction.
- Sits between the execute/memory stage (request side), the stack pointer register (sp_in/sp_ctrl) and the data memory port.

Parameters:
ADDR_W, 20, memory word-address width; only sp_in[ADDR_W-1:0] is used.
STACK_TOP, 20'hFFFFF, highest stack address; equals the stack pointer reset value.
STACK_LIMIT, 20'h00000, lowest address a push may write.

Ports:
clk  in  1  clock; all state changes on the rising edge.
Rst  in  1  reset, synchronous, active-high.
req  in  1  start transaction; sampled only in IDLE.
op  in  2  00 push16, 01 push32, 10 pop16, 11 pop32.
wdata  in  32  push data; push16 uses [15:0].
sp_in  in  32  current stack pointer; points to the next free word.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when the transaction completes.
err  out  1  valid with done: overflow or underflow, no access performed.
rdata  out  32  pop result, valid with done; pop16 zero-extends.
sp_ctrl  out  3  000 hold, 001 +2, 010 -2, 011 +1, 100 -1.
mem_addr  out  ADDR_W  memory word address.
mem_wdata  out  16  memory write data.
mem_we  out  1  memory write enable.
mem_re  out  1  memory read enable; data returns on mem_rdata one cycle later.
mem_rdata  in  16  memory read data.

Behaviour:
- States: IDLE, WR_HI, WR_LO, RD_1, RD_2, RD_CAP, DONE.
- IDLE with req=1: latch base=sp_in[ADDR_W-1:0], op and wdata. Bounds check uses ADDR_W+1-bit arithmetic, with n=1 for 16-bit ops and n=2 for 32-bit ops:
  - push is an error if base < STACK_LIMIT+n-1;
  - pop is an error if base+n > STACK_TOP.
  - On error: go to DONE with err=1; no mem access; sp_ctrl stays 000; rdata is unchanged.
- Transition sequences:
  - push16: IDLE -> WR_LO -> DONE.
  - push32: IDLE -> WR_HI -> WR_LO -> DONE.
  - pop16: IDLE -> RD_1 -> RD_CAP -> DONE.
  - pop32: IDLE -> RD_1 -> RD_2 -> RD_CAP -> DONE.
- Per-state outputs:
  - WR_HI: mem_addr=base, mem_wdata=wdata[31:16], mem_we=1.
  - WR_LO: mem_we=1. push16: addr=base, data=wdata[15:0], sp_ctrl=100. push32: addr=base-1, data=wdata[15:0], sp_ctrl=010.
  - RD_1: mem_addr=base+1, mem_re=1. pop16: sp_ctrl=011.
  - RD_2 (pop32 only): mem_addr=base+2, mem_re=1, sp_ctrl=001; register mem_rdata into rdata[15:0].
  - RD_CAP: pop16 registers mem_rdata into rdata[15:0] and clears rdata[31:16]. pop32 registers mem_rdata into rdata[31:16].
  - DONE: done=1 for exactly one cycle, then IDLE.
- Memory layout: a 32-bit push stores the high word at the higher address. A following pop32 reads low from SP+1 and high from SP+2, so push32 then pop32 returns the original value.
- sp_ctrl is nonzero in exactly one cycle per successful transaction and 000 otherwise. Since the pointer register updates on that edge, sp_in already holds the new value when done=1.
- mem_addr, mem_wdata, mem_we, mem_re and sp_ctrl are decoded from state and latched values; all are 0 in IDLE and DONE.
- Latency from the req cycle to done: push16 2, push32 3, pop16 3, pop32 4, error 1.
- req while busy is ignored, not queued. A new req is accepted the first IDLE cycle after DONE, so the back-to-back period is latency+1.
- base and addresses are latched at acceptance; sp_in changes during a transaction have no effect.
- Reset: Rst has priority over all logic.
  - Next state is IDLE.
  - busy, done, err, rdata, sp_ctrl, mem_addr, mem_wdata, mem_we, mem_re all 0.
  - Rst mid-transaction abandons it: no further writes, no sp_ctrl pulse. A partial push32 may have written only the high word; this is acceptable because the stack pointer also resets.

Test Plan:
- Reset, SP=0xFFFFF, push32 wdata=0xDEADBEEF -> writes mem[0xFFFFF]=0xDEAD, then mem[0xFFFFE]=0xBEEF with sp_ctrl=010; done at cycle 3; SP=0xFFFFD.
- Follow with pop32 -> reads 0xFFFFE then 0xFFFFF, sp_ctrl=001 in RD_2; done at cycle 4 with rdata=0xDEADBEEF, err=0; SP=0xFFFFF.
- push16 0x1234 then pop16 from SP=0xFFFFF -> mem[0xFFFFF]=0x1234, sp_ctrl 100 then 011, rdata=0x00001234, SP back to 0xFFFFF.
- pop16 at SP=0xFFFFF, and pop32 at SP=0xFFFFE -> err=1 and done one cycle after req; no mem_re; sp_ctrl stays 000.
- With STACK_LIMIT=0x00010 and SP=0x00010: push32 -> err=1 with no mem_we; push16 -> succeeds, SP becomes 0x0000F.
- Assert Rst in the WR_HI cycle of a push32 -> next cycle busy=0, mem_we=0, no done or sp_ctrl pulse. Assert req held high during busy -> exactly one transaction executes.
